// File: rtl/demux4_1_seq_if.sv
// demux4_1_seq_if: control, serial input and reconstructed-word bundle for demux4_1_seq
interface demux4_1_seq_if;
  logic start;
  logic en;
  logic d;
  logic s1;
  logic s0;
  logic [3:0] q;
  logic valid;
  logic busy;
  modport master(output start, en, d, input s1, s0, q, valid, busy);
  modport slave(input start, en, d, output s1, s0, q, valid, busy);
endinterface

// File: rtl/demux4_1_seq.sv
// demux4_1_seq: steps the 4:1 mux selects and reassembles the sampled lanes into an atomic word
module demux4_1_seq #(
  parameter bit CONTINUOUS = 1'b0
) (
  input logic clk,
  input logic rst,
  demux4_1_seq_if.slave bus
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_n;
  logic [1:0] sel, sel_n;
  logic [2:0] shadow, shadow_n;
  logic [3:0] q, q_n;
  logic valid, valid_n;
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      shadow <= '0;
      q <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      shadow <= shadow_n;
      q <= q_n;
      valid <= valid_n;
    end
  // lanes 0..2 park in shadow; lane 3 is taken straight from d so q updates in one edge
  always_comb begin
    state_n = state;
    sel_n = sel;
    shadow_n = shadow;
    q_n = q;
    valid_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        state_n = SCAN;
        sel_n = 2'd0;
      end
    end else if (bus.en) begin
      sel_n = sel + 2'd1;
      if (sel != 2'd3) shadow_n[sel] = bus.d;
      else begin
        q_n = {bus.d, shadow};
        valid_n = 1'b1;
        state_n = (CONTINUOUS || bus.start) ? SCAN : IDLE;
      end
    end
  end
  assign bus.s1 = sel[1];
  assign bus.s0 = sel[0];
  assign bus.q = q;
  assign bus.valid = valid;
  assign bus.busy = (state == SCAN);
endmodule

// File: doc/demux4_1_seq.md
# demux4_1_seq

Sequential 1-to-4 time-division demultiplexer: the receiving end of the 4:1 mux. It drives the mux select lines `s1`/`s0` through all four codes and samples the mux output `y` on `d` at each code. It then presents the reconstructed 4-bit word `q` atomically with a one-cycle `valid` strobe. It sits next to `mux4_1` and reads back the lane vector `i` one bit per clock.

## Interface
- `CONTINUOUS`, default 0: 1 = automatically restart a new scan after each frame; 0 = one scan per `start`.
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `start`  input  1  request one scan; sampled only when idle (or at frame end, see Operation)
- `en`  input  1  clock enable for the scan; 0 freezes state, counter and capture
- `d`  input  1  serial bit from mux `y`; combinationally reflects the current `{s1,s0}`
- `s1`  output  1  select MSB to mux (registered)
- `s0`  output  1  select LSB to mux (registered)
- `q`  output  4  reconstructed word; `q[k]` = value of `d` while `{s1,s0}` = k
- `valid`  output  1  one-cycle strobe; `q` updated on the same edge
- `busy`  output  1  high while a scan is in progress

## Operation
- Reset (`rst`=1 at an edge): `s1`=0, `s0`=0, `q`=4'b0000, `valid`=0, `busy`=0, internal shadow=0, state IDLE. Reset overrides `start`/`en`.
- States: IDLE, SCAN. The 2-bit counter `sel` drives `{s1,s0}` directly.
- IDLE: `busy`=0, `sel`=00.
  - Edge with `start`=1: go to SCAN, `busy`=1, `sel`=00.
  - `en` is ignored in IDLE; `start` alone launches a scan.
- SCAN, edge with `en`=1: `shadow[sel]` <= `d`, `sel` <= `sel`+1.
- SCAN, edge with `en`=1 and `sel`=11 (frame end):
  - `q` <= {`d`, `shadow[2:0]`}, `valid` <= 1, `sel` wraps to 00.
  - If `CONTINUOUS`=1 or `start`=1 on this edge: remain in SCAN, `busy` stays 1 (back-to-back frames, no bubble).
  - Else: go to IDLE, `busy` <= 0.
- SCAN, edge with `en`=0: `sel`, shadow, `q` and state hold; `valid` <= 0.
- `start` while in SCAN and not at frame end is ignored; it is not queued.
- `q` changes only on a `valid` edge. Partial scans never appear on `q`.
- `valid` is 0 on every edge that is not a frame end.

## Timing
- Edge E0 samples `start`=1 in IDLE. `{s1,s0}`=00 during the following cycle.
- Capture of lane k occurs at edge E(k+1) when `en`=1 throughout.
- E4: `q` valid and `valid`=1 for exactly one cycle. Latency is 4 cycles from the start-sampling edge, plus one cycle per `en`=0 stall.
- Continuous mode: `valid` every 4 cycles; `{s1,s0}` sequence 00,01,10,11,00,...
- `d` must settle within the same cycle that `{s1,s0}` is presented; the mux is combinational, so there is zero extra latency.
- Reset mid-scan: on the reset edge the frame is aborted, no `valid` is issued, and `q` is cleared to 0.

## Test plan
- Basic frame: mux `i`=4'b1101, pulse `start` one cycle -> `{s1,s0}` steps 00,01,10,11; `valid`=1 exactly 4 cycles after the start edge; `q`=4'b1101; `busy` falls with `valid`.
- Stall: `i`=4'b0110, `en`=0 for 2 cycles while `{s1,s0}`=01 -> select holds at 01; `valid` arrives at 6 cycles; `q`=4'b0110.
- Ignored start: `start` held high for the whole scan with `i`=4'b1010 -> frame end chains directly into a new SCAN; two `valid` strobes 4 cycles apart; `q`=4'b1010 both times; no extra frame is queued from the mid-scan `start`.
- Continuous mode (`CONTINUOUS`=1): change `i` from 4'b0011 to 4'b1100 between frames -> consecutive `q` values 0011 then 1100; `valid` period 4 cycles; `busy` stays 1.
- Reset mid-scan: assert `rst` while `{s1,s0}`=10 with `i`=4'b1111 -> next cycle `q`=0000, `busy`=0, `{s1,s0}`=00, and no `valid` strobe.
- Lane isolation: `i`=4'b0001, 4'b0010, 4'b0100, 4'b1000 in successive single-shot frames -> `q` equals `i` each frame; this checks select-to-bit mapping.
